// File: rtl/axi_mem_rw_arbiter_pkg.sv
// Shared constants for the read/write SRAM arbiter.
// Port identifiers and run-counter sizing helper.
package axi_mem_arb_pkg;

    localparam logic PORT_RD = 1'b0;
    localparam logic PORT_WR = 1'b1;

    localparam int MAX_BURST_DEF = 4;

    function automatic int run_w(input int max_burst);
        return $clog2(max_burst + 1);
    endfunction

    localparam int RUN_W = run_w(MAX_BURST_DEF);

endpackage

// File: rtl/axi_mem_rw_arbiter_if.sv
// Bus bundle between the AXI controllers, the arbiter and the SRAM.
// Optional conflict counter present when AXI_MEM_ARB_STATS_EN is defined.
interface axi_mem_rw_arbiter_if #(
    parameter int DW = 64,
    parameter int AW = 13,
    parameter int NB = DW / 8
);
    logic          rd_valid_i;
    logic          rd_wen_i;
    logic [AW-1:0] rd_a_i;
    logic          rd_grant_o;
    logic          rd_rvalid_o;
    logic          wr_valid_i;
    logic          wr_wen_i;
    logic [AW-1:0] wr_a_i;
    logic [DW-1:0] wr_d_i;
    logic [NB-1:0] wr_be_i;
    logic          wr_grant_o;
    logic          wr_rvalid_o;
    logic [DW-1:0] q_o;
    logic          MEM_CEN_o;
    logic          MEM_WEN_o;
    logic [AW-1:0] MEM_A_o;
    logic [DW-1:0] MEM_D_o;
    logic [NB-1:0] MEM_BE_o;
    logic [DW-1:0] MEM_Q_i;
`ifdef AXI_MEM_ARB_STATS_EN
    logic [31:0]   conflict_cnt_o;
`endif

    modport slave (
        input  rd_valid_i, rd_wen_i, rd_a_i,
        input  wr_valid_i, wr_wen_i, wr_a_i, wr_d_i, wr_be_i,
        input  MEM_Q_i,
        output rd_grant_o, rd_rvalid_o,
        output wr_grant_o, wr_rvalid_o,
        output q_o,
        output MEM_CEN_o, MEM_WEN_o, MEM_A_o, MEM_D_o, MEM_BE_o
`ifdef AXI_MEM_ARB_STATS_EN
        , output conflict_cnt_o
`endif
    );

    modport master (
        output rd_valid_i, rd_wen_i, rd_a_i,
        output wr_valid_i, wr_wen_i, wr_a_i, wr_d_i, wr_be_i,
        output MEM_Q_i,
        input  rd_grant_o, rd_rvalid_o,
        input  wr_grant_o, wr_rvalid_o,
        input  q_o,
        input  MEM_CEN_o, MEM_WEN_o, MEM_A_o, MEM_D_o, MEM_BE_o
`ifdef AXI_MEM_ARB_STATS_EN
        , input conflict_cnt_o
`endif
    );

endinterface

// File: rtl/axi_mem_rw_arbiter_rr_core.sv
// Bounded-run two-way arbitration core: picks RD or WR each cycle.
// The last winner keeps the memory for up to MAX_BURST contested grants.
module axi_mem_arb_rr_core
    import axi_mem_arb_pkg::*;
#(
    parameter int MAX_BURST = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    output logic [1:0] gnt,
    output logic       winner
);

    localparam int RW = run_w(MAX_BURST);
    localparam logic [RW-1:0] RUN_MAX = RW'(MAX_BURST);
    localparam logic [RW-1:0] RUN_ONE = RW'(1);

    logic          last_q;
    logic [RW-1:0] run_q;
    logic          any_req;

    // Winner: lone requester wins; on contention the incumbent keeps it until its run is spent.
    always_comb begin
        winner  = PORT_RD;
        gnt     = 2'b00;
        any_req = |req;
        if (req[0] && req[1]) begin
            winner = (run_q < RUN_MAX) ? last_q : ~last_q;
        end else if (req[1]) begin
            winner = PORT_WR;
        end
        gnt[0] = any_req && (winner == PORT_RD);
        gnt[1] = any_req && (winner == PORT_WR);
    end

    // Track the last winner and how many consecutive grants it has had.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= PORT_RD;
            run_q  <= '0;
        end else if (any_req) begin
            if (winner == last_q) begin
                if (run_q != RUN_MAX) begin
                    run_q <= run_q + RUN_ONE;
                end
            end else begin
                last_q <= winner;
                run_q  <= RUN_ONE;
            end
        end
    end

endmodule

// File: rtl/axi_mem_rw_arbiter.sv
// Merges AXI read and write controller memory requests onto one SRAM port.
// Define AXI_MEM_ARB_STATS_EN to add the contested-cycle counter output.
module axi_mem_rw_arbiter
    import axi_mem_arb_pkg::*;
#(
    parameter int AXI4_DATA_WIDTH = 64,
    parameter int AXI_NUMBYTES    = AXI4_DATA_WIDTH / 8,
    parameter int MEM_ADDR_WIDTH  = 13,
    parameter int MAX_BURST       = 4
) (
    input logic                  clk,
    input logic                  rst_n,
    axi_mem_rw_arbiter_if.slave  bus
);

    logic [1:0]                 gnt;
    logic                       winner;
    logic                       rv_q;
    logic                       own_q;
    logic                       mem_cen;
    logic                       mem_wen;
    logic [MEM_ADDR_WIDTH-1:0]  mem_a;
    logic [AXI4_DATA_WIDTH-1:0] mem_d;
    logic [AXI_NUMBYTES-1:0]    mem_be;

    axi_mem_arb_rr_core #(
        .MAX_BURST (MAX_BURST)
    ) u_core (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    ({bus.wr_valid_i, bus.rd_valid_i}),
        .gnt    (gnt),
        .winner (winner)
    );

    // Steer the winning port onto the SRAM; idle keeps the SRAM deselected.
    always_comb begin
        mem_cen = 1'b1;
        mem_wen = 1'b1;
        mem_a   = '0;
        mem_d   = '0;
        mem_be  = '0;
        unique case (1'b1)
            gnt[0]: begin
                mem_cen = 1'b0;
                mem_wen = bus.rd_wen_i;
                mem_a   = bus.rd_a_i;
            end
            gnt[1]: begin
                mem_cen = 1'b0;
                mem_wen = bus.wr_wen_i;
                mem_a   = bus.wr_a_i;
                mem_d   = bus.wr_d_i;
                mem_be  = bus.wr_be_i;
            end
            default: begin
            end
        endcase
    end

    // Remember who owns the SRAM response that returns next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rv_q  <= 1'b0;
            own_q <= PORT_RD;
        end else begin
            rv_q  <= |gnt;
            own_q <= winner;
        end
    end

    assign bus.rd_grant_o  = gnt[0];
    assign bus.wr_grant_o  = gnt[1];
    assign bus.rd_rvalid_o = rv_q & ~own_q;
    assign bus.wr_rvalid_o = rv_q & own_q;
    assign bus.q_o         = bus.MEM_Q_i;
    assign bus.MEM_CEN_o   = mem_cen;
    assign bus.MEM_WEN_o   = mem_wen;
    assign bus.MEM_A_o     = mem_a;
    assign bus.MEM_D_o     = mem_d;
    assign bus.MEM_BE_o    = mem_be;

`ifdef AXI_MEM_ARB_STATS_EN
    logic [31:0] conflict_q;

    // Count cycles where both controllers want the SRAM, saturating.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conflict_q <= '0;
        end else if (bus.rd_valid_i && bus.wr_valid_i && (conflict_q != 32'hFFFF_FFFF)) begin
            conflict_q <= conflict_q + 32'd1;
        end
    end

    assign bus.conflict_cnt_o = conflict_q;
`endif

endmodule

// File: doc/axi_mem_rw_arbiter.md
# axi_mem_rw_arbiter

Two-port arbiter that merges the memory-side request streams of the AXI read-only controller and the AXI write-only controller into the single-ported SRAM interface. It generates their `grant` inputs and multiplexes address, data and byte-enables. It tracks which port owns the read data returning one cycle later. A bounded-run fairness policy lets a burst keep the memory for up to MAX_BURST consecutive grants before the other port wins.

## Interface
- AXI4_DATA_WIDTH, 64, memory data width (read and write).
- AXI_NUMBYTES, AXI4_DATA_WIDTH/8, byte-enable width.
- MEM_ADDR_WIDTH, 13, word address width.
- MAX_BURST, 4, maximum consecutive contested grants to one port (≥1).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- rd_valid_i  in  1  read controller request.
- rd_wen_i  in  1  read port WEN (active-low write enable).
- rd_a_i  in  MEM_ADDR_WIDTH  read port address.
- rd_grant_o  out  1  read port granted this cycle.
- rd_rvalid_o  out  1  MEM_Q_i holds read-port data.
- wr_valid_i  in  1  write controller request.
- wr_wen_i  in  1  write port WEN.
- wr_a_i  in  MEM_ADDR_WIDTH  write port address.
- wr_d_i  in  AXI4_DATA_WIDTH  write data.
- wr_be_i  in  AXI_NUMBYTES  byte enables.
- wr_grant_o  out  1  write port granted.
- wr_rvalid_o  out  1  MEM_Q_i holds write-port data.
- q_o  out  AXI4_DATA_WIDTH  MEM_Q_i broadcast to both ports.
- MEM_CEN_o  out  1  SRAM chip enable, active-low.
- MEM_WEN_o  out  1  SRAM write enable, active-low.
- MEM_A_o  out  MEM_ADDR_WIDTH  SRAM address.
- MEM_D_o  out  AXI4_DATA_WIDTH  SRAM write data.
- MEM_BE_o  out  AXI_NUMBYTES  SRAM byte enables.
- MEM_Q_i  in  AXI4_DATA_WIDTH  SRAM read data, one-cycle latency.

## Operation
- State:
  - last_q: port last granted, 0 = RD, 1 = WR.
  - run_q: consecutive grants to last_q, saturating at MAX_BURST.
  - own_q, rv_q: response owner and response valid.
- Winner selection:
  - Only one port requesting: that port wins.
  - Both requesting: last_q wins if run_q < MAX_BURST, otherwise the other port wins.
  - Neither requesting: no grant.
- State update on grant:
  - Winner == last_q: run_q <= min(run_q+1, MAX_BURST).
  - Otherwise: last_q <= winner, run_q <= 1.
  - No grant: last_q and run_q hold.
- Memory mux:
  - On grant: MEM_CEN_o = 0; WEN/A/D/BE come from the winner. The RD port drives D = 0 and BE = 0.
  - Idle: MEM_CEN_o = 1, MEM_WEN_o = 1, A/D/BE = 0.
- Response tracking:
  - rv_q <= any grant; own_q <= winner.
  - rd_rvalid_o = rv_q & ~own_q; wr_rvalid_o = rv_q & own_q.
  - q_o = MEM_Q_i, unregistered.
- Reset values: last_q = RD, run_q = 0, rv_q = 0, own_q = 0. Therefore rd_rvalid_o = wr_rvalid_o = 0 after reset. Grant and MEM outputs follow the idle rule while valids are low.

## Timing
- Grants are combinational from the valids in the same cycle; zero arbitration latency. Requesters must not make valid depend on grant.
- Granted access is presented to the SRAM in the same cycle. rvalid asserts exactly one cycle later.
- A grant is never issued to a port whose valid is low. At most one grant is active per cycle.
- Worst-case wait for a contested port is MAX_BURST cycles.
- With MAX_BURST = 1, contested requests strictly alternate.
- Reset asserted mid-burst clears all state immediately. A pending rvalid is dropped.

## Configuration
- AXI_MEM_ARB_STATS_EN:
  - Defined: adds output conflict_cnt_o [31:0]. It increments on every cycle with both valids high, saturates at 0xFFFFFFFF and resets to 0.
  - Undefined: the port and counter are absent. Arbitration is identical.

## Structure
- Package axi_mem_arb_pkg holds:
  - PORT_RD = 1'b0 and PORT_WR = 1'b1.
  - Run-counter width RUN_W = $clog2(MAX_BURST+1), computed by a function.
- Sub-module axi_mem_arb_rr_core holds last_q, run_q and the winner decision. Inputs: two requests. Outputs: gnt[1:0] and winner. The top level does the datapath mux and response tracking.

## Test plan
- Single read: rd_valid_i = 1 for one cycle, A = 0x010 -> rd_grant_o = 1, MEM_CEN_o = 0, MEM_A_o = 0x010; the next cycle rd_rvalid_o = 1 and q_o = MEM_Q_i.
- Single write: wr_valid_i = 1, A = 0x020, D = 0xDEAD_BEEF_0000_0001, BE = 0xFF, WEN = 0 -> MEM_* match the inputs; wr_rvalid_o = 1 the next cycle.
- Contention with MAX_BURST = 4: both valids held high for 10 cycles after reset -> grant sequence RD×4, WR×4, RD×2.
- MAX_BURST = 1, both valids held high for 6 cycles -> RD, WR, RD, WR, RD, WR.
- Reset mid-operation: assert rst_n = 0 one cycle after a write grant -> rvalids go to 0 immediately. After release with both requesting, RD wins first.
- With AXI_MEM_ARB_STATS_EN: 7 contested cycles -> conflict_cnt_o = 7. Preload 0xFFFFFFFE and apply 3 contested cycles -> 0xFFFFFFFF.
